// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot row strobe with programmable dwell, per-key debounce,
// and a small FIFO of press codes behind a valid/ready handshake.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_TICKS = 1,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clkms,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic [15:0] key_held,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int unsigned DW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    row_q, row_d;
    logic [CW-1:0] cnt_q [16];
    logic [CW-1:0] cnt_d [16];
    logic [15:0]   held_q, held_d;
    logic [15:0]   rise;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          sample;
    logic [1:0]    row_idx;
    logic          push_req, lost_multi, push, pop, full, lost;
    logic [3:0]    ev_code;

    always_comb begin
        sample  = (dwell_q == DW'(SETTLE_TICKS));
        dwell_d = sample ? '0 : dwell_q + 1'b1;
        row_d   = sample ? {row_q[2:0], row_q[3]} : row_q;
        row_idx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_q[r]) row_idx = 2'(r);
        end
    end

    // Only keys on the row being sampled move; everything else holds.
    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        rise   = '0;
        for (int k = 0; k < 16; k++) begin
            if (sample && (row_idx == 2'(k / 4))) begin
                if (col[k % 4] != held_q[k]) begin
                    if (cnt_q[k] == CW'(DEBOUNCE_CNT - 1)) begin
                        held_d[k] = ~held_q[k];
                        cnt_d[k]  = '0;
                        rise[k]   = ~held_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end
        end
    end

    // Lowest key index wins; further presses on the same sample are lost.
    always_comb begin
        push_req   = 1'b0;
        lost_multi = 1'b0;
        ev_code    = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (rise[k]) begin
                if (!push_req) begin
                    push_req = 1'b1;
                    ev_code  = 4'(k);
                end else begin
                    lost_multi = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop  = (count_q != '0) && key_ready;
        full = (count_q == NW'(FIFO_DEPTH));
        push = push_req && (!full || pop);
        lost = lost_multi || (push_req && !push);
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = lost ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clkms or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            row_q   <= 4'b0001;
            cnt_q   <= '{default: '0};
            held_q  <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            if (push) mem_q[wr_q] <= ev_code;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        row       = row_q;
        key_held  = held_q;
        key_valid = (count_q != '0);
        key_code  = key_valid ? mem_q[rd_q] : 4'd0;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model feeds col from the driven row, and a
// scoreboard queue holds the press codes expected to leave the FIFO.
module tb_keypad_scan_ctrl;

    logic        clkms = 1'b0;
    logic        rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] key_held;
    logic        overflow;
    logic        clr_ovf;
    logic [15:0] keys;

    int tests  = 0;
    int failed = 0;
    logic [3:0] exp_q [$];

    keypad_scan_ctrl dut (
        .clkms     (clkms),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clkms = ~clkms;

    // Keypad matrix: a closed key shorts its column to the currently strobed row.
    always_comb begin
        col = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = keys[r*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted handshake must match the oldest expected code.
    always @(negedge clkms) begin
        if (rst_n && key_valid && key_ready) begin
            check("event_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("key_code", key_code, exp_q.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clkms);
        #2;
    endtask

    task automatic scans(input int n);
        cycles(8 * n);
    endtask

    task automatic tap(input int k);
        keys[k] = 1'b1;
        scans(4);
        keys[k] = 1'b0;
        scans(4);
    endtask

    logic [7:0] pat;
    logic [3:0] exp_row;
    bit         seen;

    initial begin
        rst_n     = 1'b0;
        keys      = '0;
        key_ready = 1'b0;
        clr_ovf   = 1'b0;
        cycles(3);
        check("rst_row", row, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", overflow, 0);

        // Scan sequence, two cycles per row at the default dwell.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) cycles(1);
            exp_row = 4'b0001 << ((i / 2) % 4);
            check("scan_row", row, exp_row);
            check("scan_idle", {key_valid, key_held}, 0);
        end

        // Single press of key 6, long hold, release.
        key_ready = 1'b1;
        exp_q.push_back(4'd6);
        keys[6] = 1'b1;
        scans(4);
        check("press_held6", key_held[6], 1);
        scans(10);
        check("hold_no_repeat", exp_q.size(), 0);
        keys[6] = 1'b0;
        scans(4);
        check("release_held6", key_held[6], 0);
        check("release_no_event", key_valid, 0);

        // Bouncy contact on key 0: 1,1,1,0,1,1,1,1 across scans.
        pat = 8'b1111_0111;
        exp_q.push_back(4'd0);
        for (int i = 0; i < 8; i++) begin
            keys[0] = pat[i];
            scans(1);
            if (i == 2) check("bounce_no_flip", key_held[0], 0);
            if (i == 6) check("bounce_reset", key_held[0], 0);
        end
        check("bounce_flip", key_held[0], 1);
        keys[0] = 1'b0;
        scans(4);
        check("bounce_drained", exp_q.size(), 0);

        // Backpressure: four presses fill the FIFO, the fifth is lost.
        key_ready = 1'b0;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd13);
        tap(1);
        check("bp_valid", key_valid, 1);
        check("bp_head", key_code, 1);
        tap(5);
        tap(9);
        tap(13);
        check("bp_full_no_ovf", overflow, 0);
        tap(3);
        check("bp_ovf", overflow, 1);
        check("bp_head_stable", key_code, 1);
        key_ready = 1'b1;
        cycles(10);
        check("bp_drained", exp_q.size(), 0);
        check("bp_empty", key_valid, 0);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check("bp_clr_ovf", overflow, 0);

        // Simultaneous presses of keys 13 and 15 on row 3.
        exp_q.push_back(4'd13);
        keys[13] = 1'b1;
        keys[15] = 1'b1;
        scans(4);
        cycles(2);
        check("sim_held", key_held & 16'hA000, 16'hA000);
        check("sim_ovf", overflow, 1);
        check("sim_drained", exp_q.size(), 0);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check("sim_clr_ovf", overflow, 0);
        keys = '0;
        scans(4);
        check("sim_released", key_held, 0);

        // Queue two events plus a loss, then reset mid-scan on row 2.
        key_ready = 1'b0;
        keys[2] = 1'b1;
        keys[3] = 1'b1;
        scans(4);
        keys[2] = 1'b0;
        keys[3] = 1'b0;
        scans(4);
        keys[7] = 1'b1;
        scans(4);
        check("pre_rst_valid", key_valid, 1);
        check("pre_rst_ovf", overflow, 1);
        check("pre_rst_held7", key_held[7], 1);
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            if (row == 4'b0100) seen = 1'b1;
            else cycles(1);
        end
        check("wait_row2", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_row", row, 4'b0001);
        check("arst_valid", key_valid, 0);
        check("arst_ovf", overflow, 0);
        check("arst_held", key_held, 0);
        keys = '0;
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        check("post_rst_valid", key_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 parking-system keypad. It drives the one-hot row strobes with a programmable dwell time and samples the column inputs at the end of each dwell. Each of the 16 keys is debounced with its own counter, and press events are turned into 4-bit key codes. Codes are buffered in a small FIFO behind a valid/ready handshake, so the ticket/PIN entry FSM consumes exactly one event per physical press.

Parameters:
SETTLE_TICKS, 1, extra clkms cycles a row is held before its columns are sampled; row dwell = SETTLE_TICKS+1 cycles
DEBOUNCE_CNT, 4, consecutive disagreeing samples of a key required to flip its debounced state (>=1)
FIFO_DEPTH, 4, key-event buffer depth (power of two, >=2)

Ports:
clkms  input  1  scan/system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
col  input  4  keypad column sense, 1 = contact closed on the driven row
row  output  4  one-hot row drive
key_valid  output  1  FIFO non-empty; key_code is valid
key_code  output  4  head event code = row_index*4 + col_index
key_ready  input  1  consumer accepts head when high with key_valid
key_held  output  16  debounced key state, bit row_index*4+col_index
overflow  output  1  sticky: at least one press event was lost
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (async, rst_n=0): row=4'b0001, dwell counter=0, all debounce counters=0, key_held=0, FIFO empty (key_valid=0, key_code=0), overflow=0. Takes effect mid-scan or mid-handshake; any queued events are discarded.
- Scan sequencing:
  - Dwell counter counts 0..SETTLE_TICKS while the current row is driven.
  - On the cycle where the counter equals SETTLE_TICKS, col is sampled for that row, the counter returns to 0 and row advances 0001->0010->0100->1000->0001.
  - Row is always exactly one-hot. Full scan period = 4*(SETTLE_TICKS+1) cycles (8 at defaults).
- Debounce, per key, updated only on its row's sample cycle:
  - If the sample differs from key_held[k], counter k increments.
  - When the increment would reach DEBOUNCE_CNT, key_held[k] toggles and counter k clears.
  - If the sample equals key_held[k], counter k clears (a glitch resets progress).
  - key_held updates the cycle after the sample.
- Press event: a 0->1 toggle of key_held[k] generates event code k. A 1->0 toggle (release) generates no event. Holding a key never repeats.
- Simultaneous presses: up to 4 keys in one row can toggle on the same sample. Only the lowest col_index is enqueued; each additional press is lost and sets overflow.
- FIFO and handshake:
  - Push happens on the same edge key_held toggles, so key_valid rises on that edge when the FIFO was empty: 1 cycle after the sample cycle.
  - key_code is the head entry and holds stable while key_valid=1 and key_ready=0.
  - Pop occurs on a clock edge with key_valid&&key_ready. key_ready with key_valid=0 is ignored.
- Boundaries:
  - Full and push without pop: the new event is dropped, overflow is set, FIFO contents are unchanged.
  - Full with push and pop on the same edge: both happen, no overflow.
  - Empty with push and pop on the same edge: cannot occur, because key_valid=0 blocks the pop.
  - Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
- overflow: cleared by clr_ovf on the next edge; if a loss occurs on the same edge, set wins.

Test Plan:
- Reset/scan: release rst_n, hold col=0 -> row sequence 0001,0001,0010,0010,0100,0100,1000,1000, then repeats; key_valid=0, key_held=0 throughout.
- Single press: assert col[2] only while row=0010 for 4 consecutive scans, key_ready=1 -> key_held[6]=1 and a one-cycle key_valid with key_code=6. Keep holding for 10 more scans -> no further events. Release for 4 scans -> key_held[6]=0, no event.
- Bounce: col[0] on row 0001 toggling 1,1,1,0,1,1,1,1 across scans -> no flip after the first three samples; the event for code 0 arrives only after the final 4 consecutive 1s.
- Backpressure/full: key_ready=0, produce presses of keys 1,5,9,13,3 in turn -> key_valid=1 holding key_code=1, overflow=1 after the 5th. Then key_ready=1 -> codes pop in order 1,5,9,13.
- Simultaneous: col=4'b1010 on row 1000 for 4 scans -> single event code 13, overflow=1, key_held[13]=key_held[15]=1. Pulse clr_ovf -> overflow=0.
- Async reset with 2 events queued and row=0100 -> immediately row=0001, key_valid=0, overflow=0, key_held=0.
